// File: rtl/router_pkg.sv
// Shared types and constants for the router packet-write controller.
package router_pkg;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned FIFO_CNT = 3;

  localparam logic [ADDR_W-1:0] ADDR0    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR1    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR2    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_INV = ADDR_W'(3);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_e;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic write_enb_reg;
    logic rst_int_reg;
    logic busy;
  } fsm_out_t;

endpackage

// File: rtl/router_fsm.sv
// Router write-side controller: decodes the header, sequences payload/parity loads.
// Build option ROUTER_PARITY_CHK_EN enables the CHECK_PARITY_ERROR state.
module router_fsm
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] datain,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              fifo_full,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic [ADDR_W-1:0] addr_sel,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_e            state, next_state;
  logic [ADDR_W-1:0] addr_nxt;
  fsm_out_t          out_q, out_nxt;
  logic [FIFO_CNT-1:0] empty_vec;
  logic [FIFO_CNT-1:0] soft_vec;
  logic              hdr_ok;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_ok    = pkt_valid && (datain != ADDR_INV);

  // Moore decode; applied to next_state so the flops hold the current-state view.
  function automatic fsm_out_t decode_outputs(input state_e s);
    fsm_out_t o;
    o               = '0;
    o.detect_add    = (s == DECODE_ADDRESS);
    o.lfd_state     = (s == LOAD_FIRST_DATA);
    o.ld_state      = (s == LOAD_DATA);
    o.laf_state     = (s == LOAD_AFTER_FULL);
    o.full_state    = (s == FIFO_FULL_STATE);
    o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
`ifdef ROUTER_PARITY_CHK_EN
    o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
`else
    o.rst_int_reg   = 1'b0;
`endif
    o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
    return o;
  endfunction

  // Next-state, address latch and output decode
  always_comb begin
    next_state = state;
    addr_nxt   = addr_sel;
    out_nxt    = '0;

    case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_nxt   = datain;
          next_state = empty_vec[datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      LOAD_PARITY: begin
`ifdef ROUTER_PARITY_CHK_EN
        next_state = CHECK_PARITY_ERROR;
`else
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`endif
      end
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (empty_vec[addr_sel]) next_state = LOAD_FIRST_DATA;
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    // Read-timeout abort of the active FIFO overrides every transition
    if (soft_vec[addr_sel]) next_state = DECODE_ADDRESS;

    out_nxt = decode_outputs(next_state);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= DECODE_ADDRESS;
      addr_sel <= ADDR0;
      out_q    <= decode_outputs(DECODE_ADDRESS);
    end else begin
      state    <= next_state;
      addr_sel <= addr_nxt;
      out_q    <= out_nxt;
    end
  end

  assign detect_add    = out_q.detect_add;
  assign lfd_state     = out_q.lfd_state;
  assign ld_state      = out_q.ld_state;
  assign laf_state     = out_q.laf_state;
  assign full_state    = out_q.full_state;
  assign write_enb_reg = out_q.write_enb_reg;
  assign rst_int_reg   = out_q.rst_int_reg;
  assign busy          = out_q.busy;

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port pkt_valid, input, 1 bit: source asserts while header or payload bytes are presented.
REQ-004 SHALL have port datain, input, 2 bits: header address bits, where 0, 1 and 2 select FIFO 0, 1 and 2, and 3 is invalid.
REQ-005 SHALL have ports fifo_empty_0, fifo_empty_1 and fifo_empty_2, inputs, 1 bit each: empty flags of the three FIFOs.
REQ-006 SHALL have port fifo_full, input, 1 bit: full flag of the currently selected FIFO.
REQ-007 SHALL have ports soft_reset_0, soft_reset_1 and soft_reset_2, inputs, 1 bit each: read-timeout aborts, one per FIFO.
REQ-008 SHALL have ports parity_done and low_pkt_valid, inputs, 1 bit each: status from the register block.
REQ-009 SHALL have port addr_sel, output, 2 bits: latched destination address.
REQ-010 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg and busy, outputs, 1 bit each.

Function
REQ-011 SHALL implement 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-012 SHALL latch datain into addr_sel while in DECODE_ADDRESS with pkt_valid=1 and datain!=3.
REQ-013 DECODE_ADDRESS transitions:
- pkt_valid=1, datain valid, selected FIFO empty: go to LOAD_FIRST_DATA.
- pkt_valid=1, datain valid, selected FIFO not empty: go to WAIT_TILL_EMPTY.
- Otherwise, including datain=3: stay.
REQ-014 LOAD_FIRST_DATA SHALL go to LOAD_DATA after exactly 1 cycle.
REQ-015 LOAD_DATA transitions:
- fifo_full=1: go to FIFO_FULL_STATE.
- Otherwise pkt_valid=0: go to LOAD_PARITY.
- Otherwise: stay.
REQ-016 FIFO_FULL_STATE SHALL stay while fifo_full=1 and go to LOAD_AFTER_FULL when fifo_full=0.
REQ-017 LOAD_AFTER_FULL transitions:
- parity_done=1: go to DECODE_ADDRESS.
- low_pkt_valid=1: go to LOAD_PARITY.
- Otherwise: go to LOAD_DATA.
REQ-018 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR after 1 cycle.
REQ-019 CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE when fifo_full=1, else to DECODE_ADDRESS.
REQ-020 WAIT_TILL_EMPTY SHALL stay until the empty flag selected by addr_sel is 1, then go to LOAD_FIRST_DATA.
REQ-021 soft_reset_N with N==addr_sel SHALL force DECODE_ADDRESS next cycle from any state; this has priority over every other transition. soft_reset for a non-selected FIFO SHALL have no effect.
REQ-022 Outputs SHALL be Moore-decoded from the current state only:
- detect_add = DECODE_ADDRESS
- lfd_state = LOAD_FIRST_DATA
- ld_state = LOAD_DATA
- laf_state = LOAD_AFTER_FULL
- full_state = FIFO_FULL_STATE
- rst_int_reg = CHECK_PARITY_ERROR
REQ-023 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL only.
REQ-024 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA, and 1 in every other state.

Reset
REQ-025 resetn=0 at a clock edge SHALL set state=DECODE_ADDRESS and addr_sel=0, including when it occurs mid-packet.
REQ-026 Reset SHALL take priority over soft_reset.
REQ-027 After reset, outputs SHALL be detect_add=1, busy=0, and all other outputs 0.

Configuration
REQ-028 SHALL use macro ROUTER_PARITY_CHK_EN.
- Defined: CHECK_PARITY_ERROR behaves per REQ-018 and REQ-019.
- Undefined: LOAD_PARITY goes directly to DECODE_ADDRESS (or to FIFO_FULL_STATE when fifo_full=1), CHECK_PARITY_ERROR is unreachable, and rst_int_reg is tied to 0.

Structure
REQ-029 The state enum, the address constants (ADDR0 to ADDR2, ADDR_INV=3) and the FIFO count (3) SHALL live in the shared package router_pkg.
REQ-030 There SHALL be no sub-module; next-state logic, state register, address latch and output decode all live in router_fsm.

Verification
REQ-031 Normal packet:
- Stimulus: header addr 1, fifo_empty_1=1, 4 payload bytes, then pkt_valid=0.
- Required: state sequence DECODE, LFD, LD×4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; write_enb_reg=1 for 5 cycles.
REQ-032 Busy FIFO:
- Stimulus: header addr 2 with fifo_empty_2=0 for 6 cycles, then fifo_empty_2=1.
- Required: WAIT_TILL_EMPTY with busy=1 for 6 cycles, then LOAD_FIRST_DATA.
REQ-033 Full stall:
- Stimulus: fifo_full=1 during LOAD_DATA for 3 cycles, then 0, with low_pkt_valid=1.
- Required: full_state=1 for 3 cycles, then LOAD_AFTER_FULL, then LOAD_PARITY.
REQ-034 Abort:
- Stimulus: addr 0 packet with soft_reset_0=1 mid-LOAD_DATA.
- Required: DECODE_ADDRESS next cycle.
- Stimulus: soft_reset_2=1 with addr_sel=0.
- Required: no effect.
REQ-035 Invalid address and reset:
- Stimulus: datain=3 with pkt_valid=1.
- Required: stays in DECODE_ADDRESS; addr_sel unchanged.
- Stimulus: resetn=0 in FIFO_FULL_STATE.
- Required: DECODE_ADDRESS, detect_add=1, busy=0.
